// File: rtl/rmt_ingress_arbiter_pkg.sv
// Shared definitions for the RMT ingress arbiter: FSM state encoding, counter width, default port count.
// The optional control-port strict priority (RMT_ARB_CTRL_PRIO_EN) is applied in the top module.
package rmt_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ARB  = 2'd1;
  localparam logic [1:0] ARB_FWD  = 2'd2;

  localparam int PKT_CNT_W     = 32;
  localparam int NUM_PORTS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_ARB  = ARB_ARB,
    ST_FWD  = ARB_FWD
  } arb_state_e;

endpackage

// File: rtl/rmt_ingress_arbiter_rr_picker.sv
// Rotating-priority encoder: picks the first requester after 'last', wrapping modulo NUM_PORTS.
// Purely combinational, zero latency; no flow control of its own.
module rr_picker #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_IDX_W = 2
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_IDX_W-1:0] last,
  output logic [PORT_IDX_W-1:0] gnt_idx,
  output logic                  gnt_valid
);

  always_comb begin : scan
    logic [PORT_IDX_W-1:0] cand;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    // Farthest offset first, so the nearest requester after 'last' is the final writer.
    for (int off = NUM_PORTS; off >= 1; off--) begin
      cand = PORT_IDX_W'((int'(last) + off) % NUM_PORTS);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rmt_ingress_arbiter.sv
// Packet-granular round-robin arbiter in front of the RMT pipeline s_axis; first beat 2 cycles after request, 1 bubble per packet.
// m_axis_tready is passed straight to the granted source (nothing buffered); RMT_ARB_CTRL_PRIO_EN gives port NUM_PORTS-1 strict priority.
module rmt_ingress_arbiter
  import rmt_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = NUM_PORTS_DEF,
  parameter int PORT_IDX_W           = 2
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  output logic [PORT_IDX_W-1:0]                       cur_grant,
  output logic [NUM_PORTS*PKT_CNT_W-1:0]              pkt_cnt
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  arb_state_e            state_q;
  logic [PORT_IDX_W-1:0] grant_q;
  logic [PORT_IDX_W-1:0] last_grant_q;
  logic [PKT_CNT_W-1:0]  pkt_cnt_q [NUM_PORTS];

  logic [PORT_IDX_W-1:0] rr_idx;
  logic                  rr_vld;
  logic [PORT_IDX_W-1:0] grant_d;
  logic                  grant_vld_d;
  logic                  ctrl_req;
  logic                  fwd_eop;

  rr_picker #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_rr_picker (
    .req       (s_axis_tvalid),
    .last      (last_grant_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_vld)
  );

`ifdef RMT_ARB_CTRL_PRIO_EN
  assign ctrl_req = s_axis_tvalid[NUM_PORTS-1];
`else
  assign ctrl_req = 1'b0;
`endif

  assign grant_d     = ctrl_req ? PORT_IDX_W'(NUM_PORTS - 1) : rr_idx;
  assign grant_vld_d = ctrl_req | rr_vld;
  assign fwd_eop     = (state_q == ST_FWD) && s_axis_tvalid[grant_q] &&
                       m_axis_tready && s_axis_tlast[grant_q];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= PORT_IDX_W'(NUM_PORTS - 1);
      for (int i = 0; i < NUM_PORTS; i++) pkt_cnt_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|s_axis_tvalid) state_q <= ST_ARB;
        ST_ARB: begin
          if (grant_vld_d) begin
            grant_q <= grant_d;
            // A control-port win leaves the data-port rotation pointer where it was.
            if (!ctrl_req) last_grant_q <= grant_d;
            state_q <= ST_FWD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FWD: begin
          if (fwd_eop) begin
            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + PKT_CNT_W'(1);
            state_q            <= (|s_axis_tvalid) ? ST_ARB : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_FWD) begin
      m_axis_tdata  = s_axis_tdata[int'(grant_q)*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
      m_axis_tuser  = s_axis_tuser[int'(grant_q)*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
      m_axis_tvalid = s_axis_tvalid[grant_q];
      m_axis_tlast  = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign cur_grant = grant_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt_q[i];
  end

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Directed bench for rmt_ingress_arbiter: per-port beat scripts feed the inputs, forwarded beats are logged and checked per scenario.
// Expected grant orders follow RMT_ARB_CTRL_PRIO_EN when the bench is built with it.
module tb_rmt_ingress_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  logic              clk;
  logic              aresetn;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP*KW-1:0]  s_axis_tkeep;
  logic [NP*UW-1:0]  s_axis_tuser;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tlast;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [1:0]        cur_grant;
  logic [NP*32-1:0]  pkt_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] sid   [NP][32];
  logic        slast [NP][32];
  int          slen  [NP];
  int          sptr  [NP];

  int          out_n;
  logic [31:0] out_id   [64];
  logic        out_last [64];
  logic        out_dok  [64];
  logic [1:0]  out_gnt  [64];
  int          out_cyc  [64];

  rmt_ingress_arbiter #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_PORTS            (NP),
    .PORT_IDX_W           (2)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .cur_grant     (cur_grant),
    .pkt_cnt       (pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk_id(int p, int k, int b);
    return 32'hA000_0000 | 32'(p << 16) | 32'(k << 8) | 32'(b);
  endfunction

  task automatic drive_src();
    for (int p = 0; p < NP; p++) begin
      if (sptr[p] < slen[p]) begin
        s_axis_tvalid[p]          = 1'b1;
        s_axis_tlast[p]           = slast[p][sptr[p]];
        s_axis_tdata[p*DW +: DW]  = {8{sid[p][sptr[p]]}};
        s_axis_tkeep[p*KW +: KW]  = sid[p][sptr[p]];
        s_axis_tuser[p*UW +: UW]  = {4{~sid[p][sptr[p]]}};
      end else begin
        s_axis_tvalid[p]          = 1'b0;
        s_axis_tlast[p]           = 1'b0;
        s_axis_tdata[p*DW +: DW]  = '0;
        s_axis_tkeep[p*KW +: KW]  = '0;
        s_axis_tuser[p*UW +: UW]  = '0;
      end
    end
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      slen[p] = 0;
      sptr[p] = 0;
    end
    out_n = 0;
    drive_src();
  endtask

  task automatic add_pkt(int p, int k, int nb);
    for (int b = 0; b < nb; b++) begin
      sid[p][slen[p]]   = mk_id(p, k, b);
      slast[p][slen[p]] = (b == nb - 1);
      slen[p]++;
    end
    drive_src();
  endtask

  // Handshakes are sampled mid-cycle and retired just after the following rising edge.
  initial begin : bfm
    logic [NP-1:0] fire;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready && out_n < 64) begin
        out_id[out_n]   = m_axis_tdata[31:0];
        out_dok[out_n]  = (m_axis_tdata === {8{m_axis_tdata[31:0]}}) &&
                          (m_axis_tkeep === m_axis_tdata[31:0]) &&
                          (m_axis_tuser === {4{~m_axis_tdata[31:0]}});
        out_last[out_n] = m_axis_tlast;
        out_gnt[out_n]  = cur_grant;
        out_cyc[out_n]  = cyc;
        out_n++;
      end
      @(posedge clk);
      #1;
      if (aresetn) begin
        for (int p = 0; p < NP; p++) if (fire[p]) sptr[p]++;
      end
      drive_src();
    end
  end

  task automatic apply_reset();
    aresetn       = 1'b0;
    m_axis_tready = 1'b1;
    clear_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first_p;
    aresetn       = 1'b0;
    m_axis_tready = 1'b1;
    clear_src();
    for (int p = 0; p < NP; p++) add_pkt(p, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (s_axis_tready !== 4'b0000) begin
      n_bad++; $display("FAIL reset_s_tready: got %b want 0000", s_axis_tready);
    end
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_vld_last: got %b%b want 00", m_axis_tvalid, m_axis_tlast);
    end
    n_cmp++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
      n_bad++; $display("FAIL reset_m_payload: got data[31:0] %h keep %h want 0", m_axis_tdata[31:0], m_axis_tkeep);
    end
    n_cmp++;
    if (pkt_cnt !== '0 || cur_grant !== 2'd0) begin
      n_bad++; $display("FAIL reset_cnt_grant: got cnt %h grant %0d want 0 0", pkt_cnt, cur_grant);
    end
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < 40 && out_n < 4; i++) @(posedge clk);
    #1;
`ifdef RMT_ARB_CTRL_PRIO_EN
    first_p = 3;
`else
    first_p = 0;
`endif
    n_cmp++;
    if (out_n < 1 || out_gnt[0] !== 2'(first_p) || out_id[0] !== mk_id(first_p, 0, 0)) begin
      n_bad++; $display("FAIL reset_first_winner: got n %0d grant %0d id %h want grant %0d", out_n, out_gnt[0], out_id[0], first_p);
    end
  endtask

  task automatic test_single_port();
    int c0;
    apply_reset();
    c0 = cyc;
    add_pkt(2, 0, 3);
    for (int i = 0; i < 50 && out_n < 3; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (out_n !== 3) begin
      n_bad++; $display("FAIL single_port_beats: got %0d want 3", out_n);
    end
    n_cmp++;
    if (out_cyc[0] - c0 !== 2) begin
      n_bad++; $display("FAIL single_port_latency: got %0d want 2", out_cyc[0] - c0);
    end
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if (out_id[b] !== mk_id(2, 0, b) || out_last[b] !== (b == 2) || out_dok[b] !== 1'b1 ||
          out_gnt[b] !== 2'd2 || out_cyc[b] !== out_cyc[0] + b) begin
        n_bad++; $display("FAIL single_port_beat%0d: got id %h last %b grant %0d want id %h", b, out_id[b], out_last[b], out_gnt[b], mk_id(2, 0, b));
      end
    end
    n_cmp++;
    if (pkt_cnt !== {32'd0, 32'd1, 32'd0, 32'd0} || cur_grant !== 2'd2 || m_axis_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL single_port_end: got cnt %h grant %0d vld %b want cnt[2]=1 grant 2 vld 0", pkt_cnt, cur_grant, m_axis_tvalid);
    end
  endtask

  task automatic test_round_robin();
    int ord [8];
    int seen [NP];
    apply_reset();
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, 0, 2);
      add_pkt(p, 1, 2);
    end
    for (int i = 0; i < 200 && out_n < 16; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
`ifdef RMT_ARB_CTRL_PRIO_EN
    ord = '{3, 3, 0, 1, 2, 0, 1, 2};
`else
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int p = 0; p < NP; p++) seen[p] = 0;
    n_cmp++;
    if (out_n !== 16) begin
      n_bad++; $display("FAIL rr_beats: got %0d want 16", out_n);
    end
    for (int j = 0; j < 8; j++) begin
      int p;
      int k;
      p = ord[j];
      k = seen[p];
      seen[p]++;
      for (int b = 0; b < 2; b++) begin
        int idx;
        int gap;
        idx = 2 * j + b;
        gap = (idx == 0) ? 0 : out_cyc[idx] - out_cyc[idx-1];
        n_cmp++;
        if (out_id[idx] !== mk_id(p, k, b) || out_last[idx] !== (b == 1) || out_gnt[idx] !== 2'(p) ||
            out_dok[idx] !== 1'b1 || (idx > 0 && gap != ((b == 0) ? 2 : 1))) begin
          n_bad++; $display("FAIL rr_beat%0d: got id %h grant %0d gap %0d want id %h grant %0d", idx, out_id[idx], out_gnt[idx], gap, mk_id(p, k, b), p);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (pkt_cnt[p*32 +: 32] !== 32'd2) begin
        n_bad++; $display("FAIL rr_cnt%0d: got %0d want 2", p, pkt_cnt[p*32 +: 32]);
      end
    end
  endtask

  task automatic test_backpressure();
    int ep [6];
    int eb [6];
    apply_reset();
    add_pkt(1, 0, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    add_pkt(0, 0, 2);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      m_axis_tready = 1'b0;
      #1;
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata[31:0] !== mk_id(1, 0, 1) || s_axis_tready !== 4'b0000 || cur_grant !== 2'd1) begin
        n_bad++; $display("FAIL bp_stall%0d: got vld %b id %h rdy %b grant %0d want 1 %h 0000 1", s, m_axis_tvalid, m_axis_tdata[31:0], s_axis_tready, cur_grant, mk_id(1, 0, 1));
      end
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 50 && out_n < 6; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    ep = '{1, 1, 1, 1, 0, 0};
    eb = '{0, 1, 2, 3, 0, 1};
    n_cmp++;
    if (out_n !== 6) begin
      n_bad++; $display("FAIL bp_beats: got %0d want 6", out_n);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_id[i] !== mk_id(ep[i], 0, eb[i]) || out_gnt[i] !== 2'(ep[i]) || out_dok[i] !== 1'b1) begin
        n_bad++; $display("FAIL bp_beat%0d: got id %h grant %0d want id %h grant %0d", i, out_id[i], out_gnt[i], mk_id(ep[i], 0, eb[i]), ep[i]);
      end
    end
    n_cmp++;
    if (pkt_cnt[0 +: 32] !== 32'd1 || pkt_cnt[32 +: 32] !== 32'd1) begin
      n_bad++; $display("FAIL bp_cnt: got %0d %0d want 1 1", pkt_cnt[0 +: 32], pkt_cnt[32 +: 32]);
    end
  endtask

  task automatic test_single_beat();
    int ord [2];
    apply_reset();
    add_pkt(0, 0, 1);
    add_pkt(3, 0, 1);
    for (int i = 0; i < 50 && out_n < 2; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
`ifdef RMT_ARB_CTRL_PRIO_EN
    ord = '{3, 0};
`else
    ord = '{0, 3};
`endif
    n_cmp++;
    if (out_n !== 2 || out_cyc[1] - out_cyc[0] !== 2) begin
      n_bad++; $display("FAIL sb_count_gap: got n %0d gap %0d want 2 2", out_n, out_cyc[1] - out_cyc[0]);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (out_id[i] !== mk_id(ord[i], 0, 0) || out_last[i] !== 1'b1 || out_gnt[i] !== 2'(ord[i])) begin
        n_bad++; $display("FAIL sb_beat%0d: got id %h last %b grant %0d want grant %0d", i, out_id[i], out_last[i], out_gnt[i], ord[i]);
      end
    end
    n_cmp++;
    if (pkt_cnt !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
      n_bad++; $display("FAIL sb_cnt: got %h want cnt0=1 cnt3=1", pkt_cnt);
    end
  endtask

  task automatic test_reset_midpkt();
    apply_reset();
    add_pkt(2, 0, 1);
    for (int i = 0; i < 30 && out_n < 1; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (pkt_cnt[64 +: 32] !== 32'd1) begin
      n_bad++; $display("FAIL rm_precnt: got %0d want 1", pkt_cnt[64 +: 32]);
    end
    clear_src();
    add_pkt(1, 0, 4);
    repeat (3) @(posedge clk);
    #3;
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || pkt_cnt !== '0 || cur_grant !== 2'd0) begin
      n_bad++; $display("FAIL rm_async: got vld %b rdy %b cnt %h grant %0d want 0 0000 0 0", m_axis_tvalid, s_axis_tready, pkt_cnt, cur_grant);
    end
    clear_src();
    add_pkt(1, 1, 1);
    add_pkt(0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < 30 && out_n < 2; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_n !== 2 || out_gnt[0] !== 2'd0 || out_id[0] !== mk_id(0, 0, 0) || out_gnt[1] !== 2'd1) begin
      n_bad++; $display("FAIL rm_after: got n %0d grants %0d,%0d want 2 grants 0,1", out_n, out_gnt[0], out_gnt[1]);
    end
  endtask

  task automatic test_ctrl_prio();
    int ord [8];
    int seen [NP];
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, k, 1);
      add_pkt(1, k, 1);
    end
    add_pkt(3, 0, 1);
    add_pkt(3, 1, 1);
    for (int i = 0; i < 100 && out_n < 8; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
`ifdef RMT_ARB_CTRL_PRIO_EN
    ord = '{3, 3, 0, 1, 0, 1, 0, 1};
`else
    ord = '{0, 1, 3, 0, 1, 3, 0, 1};
`endif
    for (int p = 0; p < NP; p++) seen[p] = 0;
    n_cmp++;
    if (out_n !== 8) begin
      n_bad++; $display("FAIL prio_beats: got %0d want 8", out_n);
    end
    for (int j = 0; j < 8; j++) begin
      int p;
      int k;
      p = ord[j];
      k = seen[p];
      seen[p]++;
      n_cmp++;
      if (out_id[j] !== mk_id(p, k, 0) || out_gnt[j] !== 2'(p) || (j > 0 && out_cyc[j] - out_cyc[j-1] != 2)) begin
        n_bad++; $display("FAIL prio_pkt%0d: got id %h grant %0d want id %h grant %0d", j, out_id[j], out_gnt[j], mk_id(p, k, 0), p);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    aresetn       = 1'b0;
    m_axis_tready = 1'b0;
    clear_src();
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_reset_midpkt();
    test_ctrl_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rmt_ingress_arbiter.md
Name: rmt_ingress_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single RMT pipeline ingress (pkt_filter/parser/pkt_fifo slave AXI-Stream) among NUM_PORTS upstream AXI-Stream sources, e.g. per-MAC queues plus the host control-packet queue.
- Sits directly in front of the pipeline's s_axis port.
- Never interleaves beats of different packets; forwards one whole packet per grant.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- NUM_PORTS, 4, number of requesters (2..8).
- PORT_IDX_W, 2, index width, equal to clog2(NUM_PORTS).

Ports:
- clk  in  1  axis clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  per-port data, port i at slice i.
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  per-port keep.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  per-port user.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  to pipeline.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH.
- m_axis_tvalid  out  1.
- m_axis_tlast  out  1.
- m_axis_tready  in  1  pipeline ready.
- cur_grant  out  PORT_IDX_W  currently granted port; debug.
- pkt_cnt  out  NUM_PORTS*32  per-port forwarded-packet counters, wrapping.

Behaviour:
- Reset, asynchronous on aresetn low:
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1, so port 0 wins first.
  - All s_axis_tready=0; m_axis_tvalid=0, m_axis_tlast=0; m_axis_tdata, tkeep and tuser all 0.
  - pkt_cnt all 0.
- FSM states: IDLE, ARB, FWD.
- IDLE:
  - Any s_axis_tvalid[i] high -> ARB next cycle.
  - Otherwise stay in IDLE.
  - All s_axis_tready low.
- ARB (1 cycle):
  - Picks the first requesting port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Registers grant and sets last_grant=grant; goes to FWD.
  - If the request vanished (illegal per AXIS), return to IDLE without updating last_grant.
- FWD:
  - m_axis_* = slice[grant] of the s_axis_* inputs (combinational mux from registered grant).
  - m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; all other ready bits are 0.
  - Beat transfers when tvalid&tready.
  - Transfer with tlast=1: pkt_cnt[grant]+=1 (32-bit wrap, 0xFFFFFFFF->0). Next state is ARB if any tvalid is high, else IDLE.
- Outside FWD: m_axis_tvalid=0 and m_axis_tdata/tkeep/tuser/tlast are driven 0.
- Arbitration latency:
  - 2 cycles from first tvalid in IDLE to first output beat.
  - Exactly 1 bubble cycle (ARB) between consecutive packets.
- Backpressure:
  - m_axis_tready low holds the granted source's beat. No data is registered, so no beat loss or duplication.
  - Grant never changes mid-packet, regardless of other requests.
- Single-beat packet (tlast on first beat) is legal; counter increments and the FSM re-arbitrates.
- Simultaneous tlast transfer and new requests: the new requests are seen in the same cycle and go to ARB.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is truncated downstream, which is acceptable (the pipeline is also in reset).
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro: RMT_ARB_CTRL_PRIO_EN.
- Defined: port NUM_PORTS-1 (control-packet queue) has strict priority at every ARB decision. If s_axis_tvalid[NUM_PORTS-1] is high in ARB it is granted regardless of the round-robin pointer, and last_grant is not updated, so data-port rotation order is preserved. Still packet-granular; it never preempts a packet in flight.
- Undefined: all ports, including NUM_PORTS-1, take part in plain round-robin.

Decomposition:
- Package rmt_arb_pkg:
  - state encoding constants ARB_IDLE=2'd0, ARB_ARB=2'd1, ARB_FWD=2'd2.
  - PKT_CNT_W=32.
  - default NUM_PORTS.
- One sub-module, rr_picker: purely combinational rotating-priority encoder with inputs req[NUM_PORTS] and last[PORT_IDX_W], outputs gnt_idx and gnt_valid. The FSM, grant registers, mux and counters stay in the top module.

Test Plan:
- Reset then port 2 sends a 3-beat packet with m_axis_tready=1 -> first output beat 2 cycles after tvalid; 3 beats identical to the input; pkt_cnt[2]=1; cur_grant=2; returns to IDLE.
- All 4 ports each hold two 2-beat packets -> grant order 0,1,2,3,0,1,2,3; one ARB bubble between packets; no interleaved beats; each pkt_cnt=2.
- Port 1 is mid-packet and m_axis_tready toggles 1,0,0,1 while port 0 requests -> port 1 beats stall without loss or duplication; port 0 is granted only after port 1's tlast.
- Single-beat packets back-to-back on ports 0 and 3 -> each is forwarded with tlast=1; counters 1 and 1; grants 0 then 3.
- aresetn dropped asynchronously mid-packet on port 1 -> m_axis_tvalid=0 and all tready=0 immediately; pkt_cnt cleared; after release port 0 wins the first arbitration.
- With RMT_ARB_CTRL_PRIO_EN defined, ports 0,1 and 3 all requesting continuously -> every ARB grants 3 while it requests; once port 3 is idle, the data rotation resumes 0 then 1. Without the macro, the same stimulus grants 0,1,3,0,...
